// File: rtl/mmio_uart_pkg.sv
// rtl/mmio_uart_pkg.sv - shared register map, status bits and TX FSM states for mmio_uart_tx
// Optional build macro: UART_PARITY_EN (adds the PARITY state).
package mmio_uart_pkg;

  // Register offsets inside the 4-word window.
  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_BAUD   = 2'd2;
  localparam logic [1:0] REG_RSVD   = 2'd3;

  // STATUS bit positions.
  localparam int STAT_BUSY    = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_EMPTY   = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_CNT_LSB = 4;
  localparam int STAT_CNT_MSB = 10;
  localparam int STAT_PAR     = 11;

  // Smallest divider the baud counter can handle.
  localparam logic [15:0] MIN_DIV = 16'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock show-ahead FIFO
// Ports: clk, reset (sync, active-high); push/wdata write side; pop/rdata read side
//        (rdata is the current head); full, empty and count (log2(DEPTH)+1 bits).
// A push while full is accepted only if a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers are AW bits wide, so they wrap modulo DEPTH for free.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - memory-mapped 8N1 UART transmitter with TX FIFO
// Ports: CLK, RESET (sync, active-high); daddr/ddata_w/d_rw core data bus;
//        ddata_r_o/hit_o registered read data and window hit; tx_o serial line
//        (idle high); irq_o level, FIFO empty and transmitter idle.
// Optional build macro: UART_PARITY_EN adds an even parity bit and sets STATUS bit11.
module mmio_uart_tx
  import mmio_uart_pkg::*;
#(
  parameter logic [9:0]  BASE_ADDR   = 10'h3FC,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [9:0]  daddr,
  input  logic [31:0] ddata_w,
  input  logic        d_rw,
  output logic [31:0] ddata_r_o,
  output logic        hit_o,
  output logic        tx_o,
  output logic        irq_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

`ifdef UART_PARITY_EN
  localparam logic PAR_SUPPORT = 1'b1;
`else
  localparam logic PAR_SUPPORT = 1'b0;
`endif

  // Address decode: a wrapped subtraction puts addresses below the base far out of range.
  logic [9:0] offset;
  logic       in_win;
  logic [1:0] reg_sel;
  logic       wr_en;
  logic       push_req;

  assign offset   = daddr - BASE_ADDR;
  assign in_win   = (offset < 10'd4);
  assign reg_sel  = offset[1:0];
  assign wr_en    = in_win && d_rw;
  assign push_req = wr_en && (reg_sel == REG_TXDATA);

  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [7:0]    fifo_rdata;
  logic [CW-1:0] fifo_count;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (CLK),
    .reset (RESET),
    .push  (push_req),
    .pop   (fifo_pop),
    .wdata (ddata_w[7:0]),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  logic        overflow_q;
  logic [15:0] baud_div_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      overflow_q <= 1'b0;
      baud_div_q <= DEFAULT_DIV;
    end else begin
      // A push to a full FIFO is only lost when no pop frees a slot that cycle.
      if (push_req && fifo_full && !fifo_pop)
        overflow_q <= 1'b1;
      else if (wr_en && (reg_sel == REG_STATUS) && ddata_w[STAT_OVF])
        overflow_q <= 1'b0;
      if (wr_en && (reg_sel == REG_BAUD))
        baud_div_q <= (ddata_w[15:0] < MIN_DIV) ? MIN_DIV : ddata_w[15:0];
    end
  end

  logic unused_wdata;
  assign unused_wdata = ^ddata_w[31:16];

  // TX state machine.
  tx_state_t   state_q, state_d;
  logic [15:0] baud_cnt_q, baud_cnt_d;
  logic [15:0] div_q, div_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        bit_done;
`ifdef UART_PARITY_EN
  logic        par_q, par_d;
`endif

  assign bit_done = (baud_cnt_q == div_q - 16'd1);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      baud_cnt_q <= '0;
      div_q      <= DEFAULT_DIV;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
`ifdef UART_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      div_q      <= div_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
`ifdef UART_PARITY_EN
      par_q      <= par_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q + 16'd1;
    div_d      = div_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
`ifdef UART_PARITY_EN
    par_d      = par_q;
`endif
    fifo_pop   = 1'b0;
    tx_o       = 1'b1;
    case (state_q)
      S_IDLE: begin
        baud_cnt_d = '0;
        if (!fifo_empty) begin
          // Divider is captured here so a mid-frame BAUD_DIV write waits for the next frame.
          fifo_pop  = 1'b1;
          shift_d   = fifo_rdata;
          div_d     = baud_div_q;
          bit_cnt_d = '0;
`ifdef UART_PARITY_EN
          par_d     = ^fifo_rdata;
`endif
          state_d   = S_START;
        end
      end
      S_START: begin
        tx_o = 1'b0;
        if (bit_done) begin
          baud_cnt_d = '0;
          state_d    = S_DATA;
        end
      end
      S_DATA: begin
        tx_o = shift_q[0];
        if (bit_done) begin
          baud_cnt_d = '0;
          shift_d    = {1'b0, shift_q[7:1]};
          bit_cnt_d  = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
`ifdef UART_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART_PARITY_EN
      S_PARITY: begin
        tx_o = par_q;
        if (bit_done) begin
          baud_cnt_d = '0;
          state_d    = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (bit_done) begin
          baud_cnt_d = '0;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign irq_o = fifo_empty && (state_q == S_IDLE);

  // Register read path.
  logic [31:0] status;
  logic [31:0] rd_val;

  always_comb begin
    status = '0;
    status[STAT_BUSY]                 = (state_q != S_IDLE);
    status[STAT_FULL]                 = fifo_full;
    status[STAT_EMPTY]                = fifo_empty;
    status[STAT_OVF]                  = overflow_q;
    status[STAT_CNT_MSB:STAT_CNT_LSB] = 7'(fifo_count);
    status[STAT_PAR]                  = PAR_SUPPORT;
  end

  always_comb begin
    rd_val = '0;
    case (reg_sel)
      REG_STATUS: rd_val = status;
      REG_BAUD:   rd_val = {16'd0, baud_div_q};
      default:    rd_val = '0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      hit_o     <= 1'b0;
      ddata_r_o <= '0;
    end else begin
      hit_o     <= in_win;
      ddata_r_o <= in_win ? rd_val : 32'd0;
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb/tb_mmio_uart_tx.sv - self-checking bench for mmio_uart_tx
module tb_mmio_uart_tx;

`ifdef UART_PARITY_EN
  localparam logic [31:0] PAR_FLAG = 32'h800;
  localparam int          NBITS    = 11;
`else
  localparam logic [31:0] PAR_FLAG = 32'h000;
  localparam int          NBITS    = 10;
`endif
  localparam logic [31:0] ST_IDLE_EMPTY = 32'h004 | PAR_FLAG;
  localparam logic [31:0] ST_FULL_BUSY  = 32'h083 | PAR_FLAG;
  localparam logic [31:0] ST_FULL_OVF   = 32'h08B | PAR_FLAG;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [9:0]  daddr = '0;
  logic [31:0] ddata_w = '0;
  logic        d_rw = 1'b0;
  logic [31:0] ddata_r_o;
  logic        hit_o;
  logic        tx_o;
  logic        irq_o;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  mmio_uart_tx dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .daddr     (daddr),
    .ddata_w   (ddata_w),
    .d_rw      (d_rw),
    .ddata_r_o (ddata_r_o),
    .hit_o     (hit_o),
    .tx_o      (tx_o),
    .irq_o     (irq_o)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [9:0]  addr;
    logic        wr;
    logic [31:0] wdata;
    logic        chk;
    logic        exp_hit;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vt [18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // All bus tasks start at a negedge and leave the bus idle at a later negedge.
  task automatic bus_wr(input logic [9:0] a, input logic [31:0] d);
    daddr = a; d_rw = 1'b1; ddata_w = d;
    @(negedge CLK);
    daddr = '0; d_rw = 1'b0; ddata_w = '0;
  endtask

  task automatic bus_rd(input logic [9:0] a, input string name, input logic [31:0] exp);
    daddr = a; d_rw = 1'b0;
    @(negedge CLK);
    check({name, "_hit"}, {31'd0, hit_o}, 32'd1);
    check(name, ddata_r_o, exp);
    daddr = '0;
  endtask

  task automatic wait_cyc(input int target);
    for (int i = 0; i < 2000 && cyc < target; i++) @(negedge CLK);
  endtask

  // Checks gap idle cycles then one full frame, one sample per clock.
  task automatic run_frame(input logic [7:0] data, input int div, input int gap, input string name);
    logic bits [11];
    int bad;
    bad = 0;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = data[i];
    bits[9] = ^data;
    bits[NBITS-1] = 1'b1;
    for (int g = 0; g < gap; g++) begin
      @(negedge CLK);
      if (tx_o !== 1'b1) bad++;
    end
    for (int b = 0; b < NBITS; b++)
      for (int c = 0; c < div; c++) begin
        @(negedge CLK);
        if (tx_o !== bits[b]) bad++;
      end
    check(name, bad, 0);
  endtask

  logic [7:0] bb [9];
  int e0;
  int lows;

  initial begin
    vt[0]  = '{10'h3FD, 1'b0, 32'h0,        1'b1, 1'b1, ST_IDLE_EMPTY};
    vt[1]  = '{10'h3FC, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0};
    vt[2]  = '{10'h3FE, 1'b0, 32'h0,        1'b1, 1'b1, 32'd434};
    vt[3]  = '{10'h3FF, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0};
    vt[4]  = '{10'h000, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0};
    vt[5]  = '{10'h3FB, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0};
    vt[6]  = '{10'h3FE, 1'b1, 32'h0,        1'b0, 1'b1, 32'h0};
    vt[7]  = '{10'h3FE, 1'b0, 32'h0,        1'b1, 1'b1, 32'd2};
    vt[8]  = '{10'h3FE, 1'b1, 32'h1,        1'b0, 1'b1, 32'h0};
    vt[9]  = '{10'h3FE, 1'b0, 32'h0,        1'b1, 1'b1, 32'd2};
    vt[10] = '{10'h3FE, 1'b1, 32'hABCD0007, 1'b0, 1'b1, 32'h0};
    vt[11] = '{10'h3FE, 1'b0, 32'h0,        1'b1, 1'b1, 32'd7};
    vt[12] = '{10'h3FF, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b1, 32'h0};
    vt[13] = '{10'h3FF, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0};
    vt[14] = '{10'h3FD, 1'b1, 32'hFFFFFFF7, 1'b0, 1'b1, 32'h0};
    vt[15] = '{10'h3FD, 1'b0, 32'h0,        1'b1, 1'b1, ST_IDLE_EMPTY};
    vt[16] = '{10'h3FE, 1'b1, 32'h4,        1'b0, 1'b1, 32'h0};
    vt[17] = '{10'h3FE, 1'b0, 32'h0,        1'b1, 1'b1, 32'd4};
    for (int i = 0; i < 9; i++) bb[i] = 8'(i * 37 + 5);

    // Reset state.
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    check("rst_tx", {31'd0, tx_o}, 32'd1);
    check("rst_irq", {31'd0, irq_o}, 32'd1);
    check("rst_hit", {31'd0, hit_o}, 32'd0);
    check("rst_data", ddata_r_o, 32'd0);

    // Register map vectors.
    for (int i = 0; i < 18; i++) begin
      daddr = vt[i].addr; d_rw = vt[i].wr; ddata_w = vt[i].wdata;
      @(negedge CLK);
      if (vt[i].chk) begin
        check($sformatf("vec%0d_hit", i), {31'd0, hit_o}, {31'd0, vt[i].exp_hit});
        check($sformatf("vec%0d_data", i), ddata_r_o, vt[i].exp_data);
      end
    end
    daddr = '0; d_rw = 1'b0; ddata_w = '0;

    // Single 0x55 frame at divider 4.
    bus_wr(10'h3FC, 32'h55);
    check("pop_cycle_tx", {31'd0, tx_o}, 32'd1);
    check("pop_cycle_irq", {31'd0, irq_o}, 32'd0);
    run_frame(8'h55, 4, 0, "frame_55");
    @(negedge CLK);
    check("after55_tx", {31'd0, tx_o}, 32'd1);
    check("after55_irq", {31'd0, irq_o}, 32'd1);

    // Nine back-to-back writes, overflow, clear, then push+pop while full.
    e0 = cyc + 1;
    for (int i = 0; i < 9; i++) begin
      daddr = 10'h3FC; d_rw = 1'b1; ddata_w = {24'd0, bb[i]};
      @(negedge CLK);
    end
    daddr = '0; d_rw = 1'b0; ddata_w = '0;
    bus_rd(10'h3FD, "st_full", ST_FULL_BUSY);
    bus_wr(10'h3FC, 32'hEE);
    bus_rd(10'h3FD, "st_ovf", ST_FULL_OVF);
    bus_wr(10'h3FD, 32'h8);
    bus_rd(10'h3FD, "st_ovf_clr", ST_FULL_BUSY);
    wait_cyc(e0 + 41);
    check("sync_pushpop", cyc, e0 + 41);
    bus_wr(10'h3FC, 32'hA5);
    bus_rd(10'h3FD, "st_pushpop_full", ST_FULL_BUSY);
    wait_cyc(e0 + 81);
    check("sync_frames", cyc, e0 + 81);
    for (int k = 2; k < 9; k++) run_frame(bb[k], 4, 1, $sformatf("burst_frame%0d", k));
    run_frame(8'hA5, 4, 1, "burst_frame_late");
    @(negedge CLK);
    check("drain_irq", {31'd0, irq_o}, 32'd1);
    bus_rd(10'h3FD, "st_drained", ST_IDLE_EMPTY);

    // Divider clamp and mid-frame divider change.
    bus_wr(10'h3FE, 32'h0);
    bus_rd(10'h3FE, "baud_clamp", 32'd2);
    daddr = 10'h3FC; d_rw = 1'b1; ddata_w = 32'hC3;
    @(negedge CLK);
    fork
      begin
        ddata_w = 32'h5A;
        @(negedge CLK);
        daddr = '0; d_rw = 1'b0; ddata_w = '0;
        @(negedge CLK);
        daddr = 10'h3FE; d_rw = 1'b1; ddata_w = 32'd8;
        @(negedge CLK);
        daddr = '0; d_rw = 1'b0; ddata_w = '0;
      end
      begin
        run_frame(8'hC3, 2, 0, "frame_div2");
        run_frame(8'h5A, 8, 1, "frame_div8");
      end
    join
    @(negedge CLK);
    check("div_irq", {31'd0, irq_o}, 32'd1);

    // Reset in the middle of DATA with three bytes still queued.
    bus_wr(10'h3FE, 32'd4);
    e0 = cyc + 1;
    for (int i = 0; i < 4; i++) begin
      daddr = 10'h3FC; d_rw = 1'b1; ddata_w = {24'd0, bb[i]};
      @(negedge CLK);
    end
    daddr = '0; d_rw = 1'b0; ddata_w = '0;
    wait_cyc(e0 + 8);
    check("sync_reset", cyc, e0 + 8);
    RESET = 1'b1; daddr = 10'h3FD;
    @(negedge CLK);
    RESET = 1'b0;
    check("mrst_tx", {31'd0, tx_o}, 32'd1);
    check("mrst_irq", {31'd0, irq_o}, 32'd1);
    check("mrst_hit", {31'd0, hit_o}, 32'd0);
    check("mrst_data", ddata_r_o, 32'd0);
    @(negedge CLK);
    check("mrst_st_hit", {31'd0, hit_o}, 32'd1);
    check("mrst_status", ddata_r_o, ST_IDLE_EMPTY);
    bus_rd(10'h3FE, "mrst_baud", 32'd434);
    lows = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge CLK);
      if (tx_o !== 1'b1) lows++;
    end
    check("mrst_no_frame", lows, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
